hls_launch_ctrl: RTL and testbench

- Initiator-side controller for HLS-generated datapath modules that use the Start/Done handshake.
- Buffers operand jobs in a small FIFO and presents one job at a time on a stable operand bus.
- Pulses Start for one cycle, waits for Done, captures the result bus and returns it on a valid/ready result port.
- Sits between a job source (bench or sequencer) and any generated HLSM instance; a timeout guards against a missing Done.

---
 rtl/hls_launch_ctrl.sv | 179 +++++++++++++++++
 tb/tb_hls_launch_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_launch_ctrl.sv
// Start/Done launch controller: job FIFO, one-cycle Start, Done capture with timeout, valid/ready result port.
// Optional HLS_LAUNCH_CYCLE_COUNT_EN adds lat_count (Start-to-Done cycles, saturating at 16'hFFFF).
module hls_launch_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_IN     = 6,
    parameter int NUM_OUT    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          job_valid,
    output logic                          job_ready,
    input  logic [NUM_IN*DATA_WIDTH-1:0]  job_data,
    output logic                          Start,
    input  logic                          Done,
    output logic [NUM_IN*DATA_WIDTH-1:0]  op_bus,
    input  logic [NUM_OUT*DATA_WIDTH-1:0] res_bus,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [NUM_OUT*DATA_WIDTH-1:0] res_data,
    output logic                          res_err,
    output logic                          busy
`ifdef HLS_LAUNCH_CYCLE_COUNT_EN
    ,
    output logic [15:0]                   lat_count
`endif
);

    localparam int IW = NUM_IN * DATA_WIDTH;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t state, state_n;

    logic [IW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, push, pop;
    logic          cap_done, cap_timeout;
    logic [TW-1:0] tcnt;

    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign job_ready = ~full;
    assign push      = job_valid & ~full;

    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr] <= job_data;
        end
    end

    // Pop decisions use the pre-push count, so a push into an empty FIFO is never bypassed.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        pop         = 1'b0;
        cap_done    = 1'b0;
        cap_timeout = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (Done) begin
                    cap_done = 1'b1;
                    state_n  = ST_HOLD;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    cap_timeout = 1'b1;
                    state_n     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = ST_LAUNCH;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign Start     = (state == ST_LAUNCH);
    assign res_valid = (state == ST_HOLD);
    assign busy      = (state != ST_IDLE);

    // tcnt counts the Start cycle as 1, so it equals the Start-to-Done distance on the Done cycle.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            tcnt <= '0;
        end else if (state == ST_LAUNCH) begin
            tcnt <= TW'(1);
        end else if (state == ST_WAIT) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            op_bus <= '0;
        end else if (pop) begin
            op_bus <= mem[rd_ptr];
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            res_data <= '0;
            res_err  <= 1'b0;
        end else if (cap_done) begin
            res_data <= res_bus;
            res_err  <= 1'b0;
        end else if (cap_timeout) begin
            res_data <= '0;
            res_err  <= 1'b1;
        end
    end

`ifdef HLS_LAUNCH_CYCLE_COUNT_EN
    localparam logic [15:0] TIMEOUT_SAT = (TIMEOUT > 65535) ? 16'hFFFF : 16'(TIMEOUT);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            lat_count <= '0;
        end else if (cap_done) begin
            lat_count <= (32'(tcnt) > 32'd65535) ? 16'hFFFF : 16'(tcnt);
        end else if (cap_timeout) begin
            lat_count <= TIMEOUT_SAT;
        end
    end
`endif

endmodule

// File: tb/tb_hls_launch_ctrl.sv
// Directed bench for hls_launch_ctrl with a table-driven LATENCY=4 HLSM stand-in.
module tb_hls_launch_ctrl;

    localparam int DW = 16;
    localparam int IW = 6 * DW;
    localparam int OW = 2 * DW;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          job_valid;
    logic          job_ready;
    logic [IW-1:0] job_data;
    logic          Start;
    logic          Done;
    logic [IW-1:0] op_bus;
    logic [OW-1:0] res_bus;
    logic          res_valid;
    logic          res_ready;
    logic [OW-1:0] res_data;
    logic          res_err;
    logic          busy;
`ifdef HLS_LAUNCH_CYCLE_COUNT_EN
    logic [15:0]   lat_count;
`endif

    hls_launch_ctrl #(
        .DATA_WIDTH (16),
        .NUM_IN     (6),
        .NUM_OUT    (2),
        .FIFO_DEPTH (4),
        .TIMEOUT    (8)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .job_valid (job_valid),
        .job_ready (job_ready),
        .job_data  (job_data),
        .Start     (Start),
        .Done      (Done),
        .op_bus    (op_bus),
        .res_bus   (res_bus),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .busy      (busy)
`ifdef HLS_LAUNCH_CYCLE_COUNT_EN
        ,
        .lat_count (lat_count)
`endif
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [IW-1:0] got, input logic [IW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Job table: operands a..f (word 0 in LSBs) and the results {k, j} the stand-in HLSM returns.
    logic [IW-1:0] ops [7];
    logic [OW-1:0] rs  [7];

    function automatic logic [IW-1:0] pack6(input int a, b, c, d, e, f);
        return {16'(f), 16'(e), 16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [OW-1:0] pack2(input int j, k);
        return {16'(k), 16'(j)};
    endfunction

    function automatic logic [OW-1:0] lookup(input logic [IW-1:0] o);
        logic [OW-1:0] r;
        r = 32'h7BAD_7BAD;
        for (int i = 0; i < 7; i++) begin
            if (o == ops[i]) r = rs[i];
        end
        return r;
    endfunction

    // Stand-in HLSM: latches operands on Start, raises Done 4 cycles after Start.
    logic          hl_busy;
    logic [2:0]    hl_cnt;
    logic [OW-1:0] hl_res;
    logic          done_en;
    logic          done_force;

    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            hl_busy <= 1'b0;
            hl_cnt  <= '0;
            hl_res  <= '0;
        end else if (Start) begin
            hl_busy <= 1'b1;
            hl_cnt  <= 3'd1;
            hl_res  <= lookup(op_bus);
        end else if (hl_busy) begin
            if (hl_cnt == 3'd4) hl_busy <= 1'b0;
            hl_cnt <= hl_cnt + 3'd1;
        end
    end

    assign Done    = (hl_busy && hl_cnt == 3'd4 && done_en) || done_force;
    assign res_bus = hl_res;

    int              start_cnt = 0;
    int              dbl_start = 0;
    logic            prev_start = 1'b0;
    logic [OW:0]     got_q [$];

    always @(negedge Clk) begin
        if (Start) begin
            start_cnt++;
            if (prev_start) dbl_start++;
        end
        prev_start = Start;
        if (res_valid && res_ready) got_q.push_back({res_err, res_data});
    end

    task automatic push_job(input logic [IW-1:0] d);
        bit acc;
        acc = 1'b0;
        @(posedge Clk);
        #1;
        job_data  = d;
        job_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (job_ready) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge Clk);
        #1;
        job_valid = 1'b0;
        check("push_accept", acc, 1);
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (Start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Runs one job up to the negedge where res_valid is first seen; leaves the result unacknowledged.
    task automatic run_job(input int idx, input bit to);
        bit ok;
        int n;
        int dn;
        push_job(ops[idx]);
        wait_start(ok);
        check("start_seen", ok, 1);
        check("op_bus", op_bus, ops[idx]);
        n  = 0;
        dn = -1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            n++;
            if (Done) dn = n;
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("valid_seen", ok, 1);
        check("op_hold", op_bus, ops[idx]);
        if (to) begin
            check("to_cycles", n, 8);
            check("to_data", res_data, 0);
            check("to_err", res_err, 1);
`ifdef HLS_LAUNCH_CYCLE_COUNT_EN
            check("to_lat", lat_count, 8);
`endif
        end else begin
            check("valid_cycles", n, 5);
            check("done_to_valid", dn, 4);
            check("res_data", res_data, rs[idx]);
            check("res_err", res_err, 0);
`ifdef HLS_LAUNCH_CYCLE_COUNT_EN
            check("lat_count", lat_count, 4);
`endif
        end
    endtask

    task automatic ack;
        @(posedge Clk);
        #1;
        res_ready = 1'b1;
        @(posedge Clk);
        #1;
        res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int bad;
        int sc;
        bit ok;

        ops[0] = pack6(3, 4, 5, 2, 6, 7);           rs[0] = pack2(34, 42);
        ops[1] = pack6(-2, 3, 1, -4, -5, 5);        rs[1] = pack2(20, -25);
        ops[2] = pack6(10, 20, 30, 40, 50, 60);     rs[2] = pack2(1000, 3000);
        ops[3] = pack6(-1, -1, -1, -1, -1, -1);     rs[3] = pack2(-1, 1);
        ops[4] = pack6(32767, 0, 0, 0, 0, -32768);  rs[4] = pack2(32767, 0);
        ops[5] = pack6(7, 0, 0, 0, 2, 3);           rs[5] = pack2(7, 6);
        ops[6] = pack6(0, 0, 0, 0, 100, -3);        rs[6] = pack2(0, -300);

        Rst        = 1'b0;
        job_valid  = 1'b0;
        job_data   = '0;
        res_ready  = 1'b0;
        done_en    = 1'b1;
        done_force = 1'b0;
        #23;
        check("rst_job_ready", job_ready, 1);
        check("rst_start", Start, 0);
        check("rst_op_bus", op_bus, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_err", res_err, 0);
        check("rst_busy", busy, 0);
`ifdef HLS_LAUNCH_CYCLE_COUNT_EN
        check("rst_lat", lat_count, 0);
`endif
        @(posedge Clk);
        #1;
        Rst = 1'b1;

        // Single job, positive operands
        run_job(0, 1'b0);
        #1;
        check("a_starts", start_cnt, 1);
        ack();

        // Missing Done: timeout abort
        done_en = 1'b0;
        run_job(0, 1'b1);
        ack();
        done_en = 1'b1;

        // Negative operands, then hold the result while the FIFO fills behind it
        run_job(1, 1'b0);
        base = got_q.size();
        sc   = start_cnt;
        for (int i = 2; i <= 5; i++) push_job(ops[i]);
        @(negedge Clk);
        check("full_ready", job_ready, 0);
        job_data  = ops[6];
        job_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (res_data !== rs[1] || !res_valid || Start || job_ready) bad++;
        end
        #1;
        check("hold_stable", bad, 0);
        check("hold_starts", start_cnt, sc);
        @(posedge Clk);
        #1;
        res_ready = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        check("relaunch_start", Start, 1);
        check("relaunch_op", op_bus, ops[2]);
        check("ready_after_pop", job_ready, 1);
        @(posedge Clk);
        #1;
        job_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            #1;
            if (got_q.size() >= base + 6) begin
                ok = 1'b1;
                break;
            end
        end
        check("burst_done", ok, 1);
        if (ok) begin
            check("order_1", got_q[base], {1'b0, rs[1]});
            for (int k = 2; k <= 6; k++) check($sformatf("order_%0d", k), got_q[base + k - 1], {1'b0, rs[k]});
        end
        check("burst_starts", start_cnt, sc + 5);
        check("double_start", dbl_start, 0);
        @(posedge Clk);
        #1;
        res_ready = 1'b0;

        // Reset during WAIT with a second job queued, then a stray Done
        done_en = 1'b0;
        push_job(ops[2]);
        wait_start(ok);
        check("d_start_seen", ok, 1);
        push_job(ops[3]);
        check("d_busy", busy, 1);
        Rst = 1'b0;
        #2;
        check("mid_rst_start", Start, 0);
        check("mid_rst_op_bus", op_bus, 0);
        check("mid_rst_valid", res_valid, 0);
        check("mid_rst_data", res_data, 0);
        check("mid_rst_err", res_err, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", job_ready, 1);
        @(posedge Clk);
        #1;
        Rst        = 1'b1;
        done_force = 1'b1;
        @(posedge Clk);
        #1;
        done_force = 1'b0;
        sc  = start_cnt;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (Start || res_valid || busy || !job_ready) bad++;
        end
        #1;
        check("post_rst_idle", bad, 0);
        check("post_rst_starts", start_cnt, sc);
        check("post_rst_data", res_data, 0);
        check("post_rst_err", res_err, 0);
        check("post_rst_op", op_bus, 0);
`ifdef HLS_LAUNCH_CYCLE_COUNT_EN
        check("post_rst_lat", lat_count, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
